pipeline_ctrl: RTL and testbench

//  Stall/flush sequencer for the 5-stage RV32I pipeline; sits beside the forwarding unit.

---
 rtl/pipeline_ctrl_pkg.sv | 13 +
 rtl/sat_counter.sv | 38 +++
 rtl/pipeline_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
//   pctrl_state_e : sequencer state (RUN, or waiting on the MUL/DIV unit)
//   WB_MEM        : writeback-select encoding for a load (result comes from memory)
package pipeline_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } pctrl_state_e;

    localparam logic [1:0] WB_MEM = 2'b10;

endpackage : pipeline_ctrl_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
// Ports:
//   clk   in          clock, rising edge
//   rst_n in          asynchronous active-low clear
//   en    in          count enable; +1 per enabled clock
//   cnt   out [W-1:0] current count, holds at 2^W-1
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule : sat_counter

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline.
// Detects load-use hazards between Decode and Execute, squashes wrong-path
// instructions on taken branches/jumps, and sequences the multi-cycle MUL/DIV
// unit in EX with a start/done handshake plus a timeout watchdog.
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   raddr1D, raddr2D    source registers of the instruction in Decode
//   waddrE, reg_wrE     destination register / write enable of the instruction in Execute
//   wb_selE             writeback select of the instruction in Execute (WB_MEM = load)
//   br_takenE           branch/jump taken, resolved in Execute
//   md_reqE, md_done    MUL/DIV instruction in Execute / result-valid pulse from the unit
//   md_start            start pulse to the MUL/DIV unit (same cycle as md_reqE)
//   stallF/D/E          hold PC, IF-ID, ID-EX registers
//   flushD/E/M          bubble into IF-ID, ID-EX, EX-MEM registers
//   md_timeout          sticky flag: MUL/DIV watchdog fired
//   perf_stall_cnt      saturating count of cycles with stallF=1
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       raddr1D,
    input  logic [4:0]       raddr2D,
    input  logic [4:0]       waddrE,
    input  logic             reg_wrE,
    input  logic [1:0]       wb_selE,
    input  logic             br_takenE,
    input  logic             md_reqE,
    input  logic             md_done,
    output logic             md_start,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             flushD,
    output logic             flushE,
    output logic             flushM,
    output logic             md_timeout,
    output logic [CNT_W-1:0] perf_stall_cnt
);

    localparam int                WCNT_W    = $clog2(MD_TIMEOUT);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MD_TIMEOUT - 1);

    pctrl_state_e      state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              md_timeout_q, md_timeout_d;
    logic              lu;
    logic              md_expired;

    // Load in E whose destination feeds the instruction in D; x0 never hazards.
    assign lu = reg_wrE && (wb_selE == WB_MEM) && (waddrE != 5'd0) &&
                ((waddrE == raddr1D) || (waddrE == raddr2D));

    // Last permitted wait cycle with no result yet: abort this cycle.
    assign md_expired = (wcnt_q == WCNT_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            wcnt_q       <= '0;
            md_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            md_timeout_q <= md_timeout_d;
        end
    end

    // Next-state logic
    // NOTE: every variable gets a default at the top of the block so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        md_timeout_d = md_timeout_q;
        case (state_q)
            RUN: begin
                wcnt_d = '0;
                // Branch and load-use take priority; md_done is ignored here.
                if (!br_takenE && !lu && md_reqE) begin
                    state_d = MD_WAIT;
                end
            end
            MD_WAIT: begin
                wcnt_d = wcnt_q + 1'b1;
                if (md_done) begin
                    // A result arriving on the final cycle beats the watchdog.
                    state_d = RUN;
                end else if (md_expired) begin
                    state_d      = RUN;
                    md_timeout_d = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Output logic
    always_comb begin
        md_start = 1'b0;
        stallF   = 1'b0;
        stallD   = 1'b0;
        stallE   = 1'b0;
        flushD   = 1'b0;
        flushE   = 1'b0;
        flushM   = 1'b0;
        case (state_q)
            RUN: begin
                if (br_takenE) begin
                    // Instruction in D is wrong-path; it cannot cause a real stall.
                    flushD = 1'b1;
                    flushE = 1'b1;
                end else if (lu) begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    flushE = 1'b1;
                end else if (md_reqE) begin
                    md_start = 1'b1;
                    stallF   = 1'b1;
                    stallD   = 1'b1;
                    stallE   = 1'b1;
                    flushM   = 1'b1;
                end
            end
            MD_WAIT: begin
                if (md_done) begin
                    // Release everything: EX-MEM captures the result this cycle.
                end else if (md_expired) begin
                    // Drop the MUL/DIV instruction: ID-EX takes a bubble while F/D hold.
                    stallF = 1'b1;
                    stallD = 1'b1;
                    flushE = 1'b1;
                    flushM = 1'b1;
                end else begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    stallE = 1'b1;
                    flushM = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign md_timeout = md_timeout_q;

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (stallF),
        .cnt   (perf_stall_cnt)
    );

endmodule : pipeline_ctrl

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl. Two instances share the stimulus:
//   dut_a : MD_TIMEOUT=64, CNT_W=32 (hazards, branches, normal MUL/DIV)
//   dut_b : MD_TIMEOUT=4,  CNT_W=3  (watchdog, reset mid-wait, saturation)
// Control outputs are compared as {md_start, stallF, stallD, stallE, flushD, flushE, flushM}.
module tb_pipeline_ctrl;

    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_LU   = 7'b0110010;
    localparam logic [6:0] C_BR   = 7'b0000110;
    localparam logic [6:0] C_MDS  = 7'b1111001;
    localparam logic [6:0] C_MDW  = 7'b0111001;
    localparam logic [6:0] C_ABT  = 7'b0110011;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] raddr1D, raddr2D, waddrE;
    logic       reg_wrE, br_takenE, md_reqE, md_done;
    logic [1:0] wb_selE;

    logic        md_start_a, stallF_a, stallD_a, stallE_a, flushD_a, flushE_a, flushM_a, md_timeout_a;
    logic [31:0] cnt_a;
    logic        md_start_b, stallF_b, stallD_b, stallE_b, flushD_b, flushE_b, flushM_b, md_timeout_b;
    logic [2:0]  cnt_b;
    logic [6:0]  ctl_a, ctl_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign ctl_a = {md_start_a, stallF_a, stallD_a, stallE_a, flushD_a, flushE_a, flushM_a};
    assign ctl_b = {md_start_b, stallF_b, stallD_b, stallE_b, flushD_b, flushE_b, flushM_b};

    pipeline_ctrl #(.MD_TIMEOUT(64), .CNT_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .raddr1D(raddr1D), .raddr2D(raddr2D), .waddrE(waddrE),
        .reg_wrE(reg_wrE), .wb_selE(wb_selE), .br_takenE(br_takenE), .md_reqE(md_reqE),
        .md_done(md_done), .md_start(md_start_a), .stallF(stallF_a), .stallD(stallD_a),
        .stallE(stallE_a), .flushD(flushD_a), .flushE(flushE_a), .flushM(flushM_a),
        .md_timeout(md_timeout_a), .perf_stall_cnt(cnt_a)
    );

    pipeline_ctrl #(.MD_TIMEOUT(4), .CNT_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .raddr1D(raddr1D), .raddr2D(raddr2D), .waddrE(waddrE),
        .reg_wrE(reg_wrE), .wb_selE(wb_selE), .br_takenE(br_takenE), .md_reqE(md_reqE),
        .md_done(md_done), .md_start(md_start_b), .stallF(stallF_b), .stallD(stallD_b),
        .stallE(stallE_b), .flushD(flushD_b), .flushE(flushE_b), .flushM(flushM_b),
        .md_timeout(md_timeout_b), .perf_stall_cnt(cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change here, outputs are sampled at negedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        raddr1D   = 5'd0;
        raddr2D   = 5'd0;
        waddrE    = 5'd0;
        reg_wrE   = 1'b0;
        wb_selE   = 2'b00;
        br_takenE = 1'b0;
        md_reqE   = 1'b0;
        md_done   = 1'b0;
    endtask

    task automatic load_in_e(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        reg_wrE = 1'b1;
        wb_selE = 2'b10;
        waddrE  = rd;
        raddr1D = rs1;
        raddr2D = rs2;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();

        // Reset state
        @(negedge clk);
        check("rst_ctl_a", ctl_a, C_NONE);
        check("rst_cnt_a", cnt_a, 32'd0);
        check("rst_to_a", md_timeout_a, 1'b0);
        tick();
        rst_n = 1'b1;

        // 1. Load-use on rs1, then on rs2
        load_in_e(5'd5, 5'd5, 5'd0);
        @(negedge clk);
        check("lu_rs1", ctl_a, C_LU);
        tick();
        idle_inputs();
        @(negedge clk);
        check("lu_bubble", ctl_a, C_NONE);
        check("lu_cnt1", cnt_a, 32'd1);
        tick();
        load_in_e(5'd5, 5'd3, 5'd5);
        @(negedge clk);
        check("lu_rs2", ctl_a, C_LU);
        tick();

        // 2. No hazard for x0, non-writing, or non-load producers
        load_in_e(5'd0, 5'd0, 5'd0);
        @(negedge clk);
        check("lu_x0", ctl_a, C_NONE);
        tick();
        load_in_e(5'd5, 5'd5, 5'd0);
        reg_wrE = 1'b0;
        @(negedge clk);
        check("lu_nowr", ctl_a, C_NONE);
        tick();
        load_in_e(5'd5, 5'd5, 5'd0);
        wb_selE = 2'b01;
        @(negedge clk);
        check("lu_alu", ctl_a, C_NONE);
        check("lu_cnt2", cnt_a, 32'd2);
        tick();

        // 3. Taken branch overrides load-use
        load_in_e(5'd5, 5'd5, 5'd0);
        br_takenE = 1'b1;
        @(negedge clk);
        check("br_lu", ctl_a, C_BR);
        tick();
        idle_inputs();
        @(negedge clk);
        check("br_cnt", cnt_a, 32'd2);
        tick();

        // 4. MUL/DIV, done 5 cycles after start; done in the start cycle is ignored
        md_reqE = 1'b1;
        md_done = 1'b1;
        @(negedge clk);
        check("md_start", ctl_a, C_MDS);
        tick();
        md_done = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check($sformatf("md_wait%0d", i), ctl_a, C_MDW);
            tick();
        end
        md_done = 1'b1;
        @(negedge clk);
        check("md_done", ctl_a, C_NONE);
        tick();
        md_done = 1'b0;
        // Back-to-back MUL/DIV restarts cleanly
        @(negedge clk);
        check("md_b2b", ctl_a, C_MDS);
        check("md_cnt", cnt_a, 32'd7);
        tick();
        md_done = 1'b1;
        @(negedge clk);
        check("md_b2b_done", ctl_a, C_NONE);
        tick();
        idle_inputs();
        @(negedge clk);
        check("md_run", ctl_a, C_NONE);
        check("md_cnt2", cnt_a, 32'd8);
        check("md_to_a", md_timeout_a, 1'b0);

        // 5. Watchdog on dut_b (MD_TIMEOUT=4)
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        md_reqE = 1'b1;
        @(negedge clk);
        check("to_start", ctl_b, C_MDS);
        tick();
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check($sformatf("to_wait%0d", i), ctl_b, C_MDW);
            tick();
        end
        @(negedge clk);
        check("to_abort", ctl_b, C_ABT);
        check("to_pre", md_timeout_b, 1'b0);
        tick();
        md_reqE = 1'b0;
        @(negedge clk);
        check("to_run", ctl_b, C_NONE);
        check("to_flag", md_timeout_b, 1'b1);
        check("to_cnt", cnt_b, 3'd5);
        tick();
        // Later MUL/DIV completes normally; flag stays set
        md_reqE = 1'b1;
        tick();
        md_done = 1'b1;
        tick();
        idle_inputs();
        @(negedge clk);
        check("to_sticky", md_timeout_b, 1'b1);
        check("to_cnt6", cnt_b, 3'd6);
        tick();
        // Done on the final wait cycle beats the watchdog
        md_reqE = 1'b1;
        tick();
        tick();
        tick();
        tick();
        md_done = 1'b1;
        @(negedge clk);
        check("to_done_wins", ctl_b, C_NONE);
        tick();
        idle_inputs();
        @(negedge clk);
        check("to_sat", cnt_b, 3'd7);

        // 6. Reset mid-MD_WAIT returns to RUN at once
        tick();
        md_reqE = 1'b1;
        tick();
        tick();
        #2;
        rst_n   = 1'b0;
        md_reqE = 1'b0;
        #1;
        check("mid_rst_ctl", ctl_b, C_NONE);
        check("mid_rst_cnt", cnt_b, 3'd0);
        check("mid_rst_to", md_timeout_b, 1'b0);
        tick();
        rst_n = 1'b1;
        // 9 stall cycles on a 3-bit counter saturate at 7
        load_in_e(5'd7, 5'd7, 5'd0);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 6) check("sat_mid", cnt_b, 3'd6);
            tick();
        end
        idle_inputs();
        @(negedge clk);
        check("sat_hold", cnt_b, 3'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pipeline_ctrl
